// File: rtl/mctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings,
// opcode constants and datapath select encodings.
package mctrl_pkg;

  typedef logic [3:0] state_t;

  // FETCH is encoded as zero so a forced-low state_o reads as FETCH
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_LD_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WR   = 4'd5;
  localparam logic [3:0] ST_R_EXEC   = 4'd6;
  localparam logic [3:0] ST_R_WB     = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JUMP     = 4'd9;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ASRCB_REG     = 2'b00;
  localparam logic [1:0] ASRCB_FOUR    = 2'b01;
  localparam logic [1:0] ASRCB_IMM     = 2'b10;
  localparam logic [1:0] ASRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // True for the five opcodes the controller knows how to sequence
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Combinational output decode: maps the current state (plus mem_ready
// for the fetch handshake and op for illegal-opcode flagging) to the
// datapath enables and selects.
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic [5:0] op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] aluop,
  output logic       illegal_op
);

  // Moore decode per state; everything defaults to inactive
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASRCB_REG;
    pc_source     = PCSRC_ALU;
    aluop         = ALUOP_ADD;
    illegal_op    = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASRCB_FOUR;
        // IR load and PC+4 commit only when the instruction word arrives
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b  = ASRCB_IMM_SH2;
        illegal_op = !is_legal_op(op);
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_LD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ASRCB_REG;
        aluop     = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ASRCB_REG;
        aluop         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mctrl_fsm.sv
// Multi-cycle processor main controller: state register, next-state
// logic, and reset gating of the decoded datapath controls.
module mctrl_fsm
  import mctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       aluop1,
  output logic       aluop0,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t     state;
  state_t     state_nxt;
  logic       d_pc_write, d_pc_write_cond, d_iord, d_mem_read, d_mem_write;
  logic       d_ir_write, d_mem_to_reg, d_reg_dst, d_reg_write, d_alu_src_a;
  logic [1:0] d_alu_src_b, d_pc_source, d_aluop;
  logic       d_illegal_op;

  // State register with synchronous active-low reset to FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic; op matters only in DECODE and MEM_ADDR, and any
  // unused encoding falls back to FETCH
  always_comb begin
    state_nxt = ST_FETCH;
    case (state)
      ST_FETCH:    state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
          OP_R:         state_nxt = ST_R_EXEC;
          OP_BEQ:       state_nxt = ST_BRANCH;
          OP_J:         state_nxt = ST_JUMP;
          default:      state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: begin
        if (op == OP_LW)      state_nxt = ST_MEM_RD;
        else if (op == OP_SW) state_nxt = ST_MEM_WR;
        else                  state_nxt = ST_FETCH;
      end
      ST_MEM_RD:   state_nxt = mem_ready ? ST_LD_WB : ST_MEM_RD;
      ST_MEM_WR:   state_nxt = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_R_EXEC:   state_nxt = ST_R_WB;
      default:     state_nxt = ST_FETCH;
    endcase
  end

  mctrl_decode u_decode (
    .state         (state),
    .mem_ready     (mem_ready),
    .op            (op),
    .pc_write      (d_pc_write),
    .pc_write_cond (d_pc_write_cond),
    .iord          (d_iord),
    .mem_read      (d_mem_read),
    .mem_write     (d_mem_write),
    .ir_write      (d_ir_write),
    .mem_to_reg    (d_mem_to_reg),
    .reg_dst       (d_reg_dst),
    .reg_write     (d_reg_write),
    .alu_src_a     (d_alu_src_a),
    .alu_src_b     (d_alu_src_b),
    .pc_source     (d_pc_source),
    .aluop         (d_aluop),
    .illegal_op    (d_illegal_op)
  );

  // Outputs are forced low combinationally while rst_n is low, so an
  // in-flight memory write is dropped in the very cycle reset is seen
  assign pc_write      = rst_n & d_pc_write;
  assign pc_write_cond = rst_n & d_pc_write_cond;
  assign iord          = rst_n & d_iord;
  assign mem_read      = rst_n & d_mem_read;
  assign mem_write     = rst_n & d_mem_write;
  assign ir_write      = rst_n & d_ir_write;
  assign mem_to_reg    = rst_n & d_mem_to_reg;
  assign reg_dst       = rst_n & d_reg_dst;
  assign reg_write     = rst_n & d_reg_write;
  assign alu_src_a     = rst_n & d_alu_src_a;
  assign alu_src_b     = rst_n ? d_alu_src_b : 2'b00;
  assign pc_source     = rst_n ? d_pc_source : 2'b00;
  assign aluop1        = rst_n & d_aluop[1];
  assign aluop0        = rst_n & d_aluop[0];
  assign illegal_op    = rst_n & d_illegal_op;
  assign state_o       = rst_n ? state : 4'd0;

endmodule

// File: tb/tb_mctrl_fsm.sv
// Scoreboard bench for mctrl_fsm: each driven cycle pushes the expected
// state and output vector; a negedge monitor pops and compares.
module tb_mctrl_fsm;
  import mctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic       aluop1, aluop0, illegal_op;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] outs;
  } exp_t;

  exp_t sb[$];

  mctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .aluop1(aluop1), .aluop0(aluop0), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Output vector layout:
  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
  //  pc_source[1:0], aluop1, aluop0, illegal_op}
  function automatic logic [16:0] pack(
      input logic pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa,
      input logic [1:0] asb, pcs, aop, input logic ill);
    return {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ill};
  endfunction

  // Expected outputs from the controller's state table
  function automatic logic [16:0] model(input logic r, input logic [3:0] st,
                                        input logic rdy, input logic [5:0] o);
    logic legal;
    legal = (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
            (o == 6'b000100) || (o == 6'b000010);
    if (!r) return 17'd0;
    case (st)
      ST_FETCH:    return pack(rdy,0,0,1,0,rdy,0,0,0,0,2'b01,2'b00,2'b00,0);
      ST_DECODE:   return pack(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!legal);
      ST_MEM_ADDR: return pack(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
      ST_MEM_RD:   return pack(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
      ST_LD_WB:    return pack(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
      ST_MEM_WR:   return pack(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
      ST_R_EXEC:   return pack(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0);
      ST_R_WB:     return pack(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
      ST_BRANCH:   return pack(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
      ST_JUMP:     return pack(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0);
      default:     return 17'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the DUT must show in it
  task automatic step(input logic r, input logic [5:0] o, input logic rdy,
                      input logic [3:0] st);
    exp_t e;
    rst_n     = r;
    op        = o;
    mem_ready = rdy;
    e.st      = r ? st : 4'd0;
    e.outs    = model(r, st, rdy, o);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare mid-cycle, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    logic [16:0] got;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
             aluop1, aluop0, illegal_op};
      check("state", {28'd0, state_o}, {28'd0, e.st});
      check("outs", {15'd0, got}, {15'd0, e.outs});
      cyc++;
    end
  end

  initial begin
    @(posedge clk); #1;
    // Reset held for two cycles: all outputs zero
    step(0, 6'b000000, 1, ST_FETCH);
    step(0, 6'b100011, 1, ST_FETCH);
    // R-type with mem_ready high
    step(1, 6'b000000, 1, ST_FETCH);
    step(1, 6'b000000, 1, ST_DECODE);
    step(1, 6'b111111, 1, ST_R_EXEC);
    step(1, 6'b101011, 1, ST_R_WB);
    // lw with two MEM_RD wait cycles; op scrambled where it must be ignored
    step(1, 6'b100011, 1, ST_FETCH);
    step(1, 6'b100011, 1, ST_DECODE);
    step(1, 6'b100011, 1, ST_MEM_ADDR);
    step(1, 6'b111111, 0, ST_MEM_RD);
    step(1, 6'b000010, 0, ST_MEM_RD);
    step(1, 6'b100011, 1, ST_MEM_RD);
    step(1, 6'b000100, 1, ST_LD_WB);
    // beq
    step(1, 6'b000100, 1, ST_FETCH);
    step(1, 6'b000100, 1, ST_DECODE);
    step(1, 6'b000000, 1, ST_BRANCH);
    // j
    step(1, 6'b000010, 1, ST_FETCH);
    step(1, 6'b000010, 1, ST_DECODE);
    step(1, 6'b100011, 1, ST_JUMP);
    // Illegal opcode: one-cycle flag in DECODE, then FETCH
    step(1, 6'b111111, 1, ST_FETCH);
    step(1, 6'b111111, 1, ST_DECODE);
    step(1, 6'b111111, 1, ST_FETCH);
    step(1, 6'b111111, 1, ST_DECODE);
    step(1, 6'b010101, 1, ST_FETCH);
    // sw reset on second MEM_WR cycle
    step(1, 6'b101011, 1, ST_DECODE);
    step(1, 6'b101011, 1, ST_MEM_ADDR);
    step(1, 6'b101011, 0, ST_MEM_WR);
    step(0, 6'b101011, 0, ST_MEM_WR);
    step(1, 6'b101011, 0, ST_FETCH);
    // FETCH stalled three cycles, then completes
    step(1, 6'b101011, 0, ST_FETCH);
    step(1, 6'b101011, 0, ST_FETCH);
    step(1, 6'b101011, 1, ST_FETCH);
    // sw with one MEM_WR wait, mem_write held throughout
    step(1, 6'b101011, 1, ST_DECODE);
    step(1, 6'b101011, 1, ST_MEM_ADDR);
    step(1, 6'b000000, 0, ST_MEM_WR);
    step(1, 6'b000000, 1, ST_MEM_WR);
    step(1, 6'b000000, 1, ST_FETCH);
    // Reset during a MEM_RD wait
    step(1, 6'b100011, 1, ST_DECODE);
    step(1, 6'b100011, 1, ST_MEM_ADDR);
    step(1, 6'b100011, 0, ST_MEM_RD);
    step(0, 6'b100011, 1, ST_MEM_RD);
    step(1, 6'b100011, 1, ST_FETCH);
    step(1, 6'b000000, 1, ST_DECODE);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mctrl_fsm.md
MCTRL_FSM -- requirements
Module: mctrl_fsm

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-003 op  input  6  opcode from the instruction register (IR[31:26]).
REQ-004 mem_ready  input  1  memory handshake; 1 = current access completes this cycle.
REQ-005 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write  output  1 each  datapath enables.
REQ-006 mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath selects and enables.
REQ-007 alu_src_b  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 pc_source  output  2  PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 aluop1, aluop0  output  1 each  ALU-control class: 00 add, 01 sub, 10 R-type (function-field decode).
REQ-010 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-011 state_o  output  4  current state encoding, for debug.

Function
REQ-012 States: FETCH, DECODE, MEM_ADDR, MEM_RD, LD_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP.
REQ-013 Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010.
REQ-014 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00.
REQ-015 FETCH: ir_write=1 and pc_write=1 only in a cycle where mem_ready=1.
REQ-016 FETCH: stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, aluop=00 (branch-target precompute).
REQ-018 DECODE next state: lw/sw -> MEM_ADDR; R -> R_EXEC; beq -> BRANCH; j -> JUMP.
REQ-019 DECODE, any other opcode: next state FETCH; illegal_op=1 for that DECODE cycle only.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=00.
REQ-021 MEM_ADDR next state: lw -> MEM_RD; sw -> MEM_WR.
REQ-022 MEM_RD: mem_read=1, iord=1; holds until mem_ready=1, then -> LD_WB.
REQ-023 LD_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then -> FETCH.
REQ-024 MEM_WR: mem_write=1, iord=1; holds until mem_ready=1, then -> FETCH.
REQ-025 mem_write stays asserted through every MEM_WR wait cycle.
REQ-026 R_EXEC: alu_src_a=1, alu_src_b=00, aluop=10; then -> R_WB.
REQ-027 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then -> FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01; then -> FETCH.
REQ-029 JUMP: pc_write=1, pc_source=10; then -> FETCH.
REQ-030 Every output not named for a state SHALL be 0 in that state.
REQ-031 Outputs are Moore functions of state; the only exceptions are REQ-015 (mem_ready gating) and REQ-019 (illegal_op).
REQ-032 Latency with mem_ready held at 1: R 4 cycles, lw 5, sw 4, beq 3, j 3.
REQ-033 op is sampled only in DECODE and MEM_ADDR; changes to op in other states have no effect.
REQ-034 Illegal or unused state encodings SHALL go to FETCH on the next clock.

Reset
REQ-035 rst_n=0 at a rising edge: state becomes FETCH, whatever the current state (including mid-access).
REQ-036 While rst_n=0, every output SHALL be 0, including the mem_read, mem_write and aluop outputs.
REQ-037 First cycle with rst_n=1: FETCH outputs are driven.
REQ-038 A reset during MEM_WR SHALL drop mem_write in the same cycle rst_n is low.

Structure
REQ-039 Shared package mctrl_pkg holds the state enumeration (4-bit), the opcode constants and the alu_src_b / pc_source / aluop encodings.
REQ-040 The state register and next-state logic live in mctrl_fsm.
REQ-041 Output decode lives in one sub-module, mctrl_decode: combinational; inputs state, mem_ready, op; drives all datapath outputs.

Verification
REQ-042 Reset, then R-type (op=000000), mem_ready=1:
- states FETCH, DECODE, R_EXEC, R_WB, then FETCH;
- aluop=10 in R_EXEC;
- reg_write=1 and reg_dst=1 in R_WB.
REQ-043 lw (100011) with mem_ready=0 for 2 cycles in MEM_RD:
- MEM_RD held 3 cycles with iord=1 and mem_read=1;
- LD_WB then asserts reg_write=1 and mem_to_reg=1;
- 7 cycles in total.
REQ-044 beq (000100):
- DECODE drives alu_src_b=11;
- BRANCH drives aluop=01, pc_write_cond=1, pc_source=01;
- back in FETCH after 3 cycles.
REQ-045 op=111111:
- illegal_op=1 for exactly one cycle in DECODE;
- next state FETCH;
- no reg_write and no mem_write at any point.
REQ-046 sw (101011) with rst_n driven low on the 2nd MEM_WR cycle:
- that cycle, all outputs are 0;
- the following cycle is FETCH.
REQ-047 FETCH with mem_ready=0 for 3 cycles:
- ir_write=0 and pc_write=0 throughout;
- both are 1 only in the cycle mem_ready=1.
